// File: rtl/hsi_pkg.sv
// Shared definitions for the host command interface: sync byte, frame
// state encoding and default frame sizing.
package hsi_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         LEN_MAX_DEF = 16;
  localparam int         CMD_WR_BIT  = 7;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_CMD,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_EMIT
  } state_e;

endpackage

// File: rtl/cmd_payload_buf.sv
// Payload staging RAM: synchronous write, registered read with read enable
// so the output holds the presented word while a write is back-pressured.
module cmd_payload_buf #(
  parameter int LEN_MAX = 16,
  parameter int AW      = 4
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [LEN_MAX];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)    rdata_q <= 8'h00;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cmd_deframer.sv
// Hunts for a sync byte, parses cmd/len/payload/csum frames from the FTDI
// byte handshake and, once the checksum verifies, issues writes or a read.
module cmd_deframer
  import hsi_pkg::*;
#(
  parameter int LEN_MAX        = LEN_MAX_DEF,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] q,
  input  logic       byte_hold,
  output logic       cd_busy,
  output logic       rd_en,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_req,
  output logic [6:0] rd_addr,
  output logic [4:0] rd_len,
  output logic       pkt_ok,
  output logic       pkt_err
);

  localparam int             AW        = (LEN_MAX > 1) ? $clog2(LEN_MAX) : 1;
  localparam int             TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0]     LEN_LIMIT = 8'(LEN_MAX);

  state_e        state_q, state_d;
  logic          cd_busy_q, cd_busy_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    csum_q, csum_d;
  logic [4:0]    len_q, len_d;
  logic [4:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          wr_valid_q, wr_valid_d;
  logic [6:0]    wr_addr_q, wr_addr_d;
  logic          rd_req_q, rd_req_d;
  logic [6:0]    rd_addr_q, rd_addr_d;
  logic [4:0]    rd_len_q, rd_len_d;
  logic          pkt_ok_q, pkt_ok_d;
  logic          pkt_err_q, pkt_err_d;

  logic          capture, in_frame, timeout, len_bad, csum_match, last_idx, wr_fire;
  logic [4:0]    idx_nxt;
  logic          buf_we, buf_re;
  logic [AW-1:0] buf_raddr;

  // A byte is taken once per byte_hold assertion; EMIT leaves it pending.
  assign capture    = byte_hold && !cd_busy_q && (state_q != ST_EMIT);
  assign in_frame   = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                      (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign timeout    = in_frame && !capture && (tmo_q == TMO_LIMIT);
  assign len_bad    = (q == 8'h00) || (q > LEN_LIMIT);
  assign csum_match = (q == csum_q);
  assign idx_nxt    = idx_q + 5'd1;
  assign last_idx   = (idx_q == (len_q - 5'd1));
  assign wr_fire    = wr_valid_q && wr_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_HUNT;
      cd_busy_q  <= 1'b0;
      len_q      <= 5'd0;
      idx_q      <= 5'd0;
      tmo_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 7'd0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= 7'd0;
      rd_len_q   <= 5'd0;
      pkt_ok_q   <= 1'b0;
      pkt_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cd_busy_q  <= cd_busy_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      pkt_ok_q   <= pkt_ok_d;
      pkt_err_q  <= pkt_err_d;
    end
  end

  always_ff @(posedge clk) begin
    cmd_q  <= cmd_d;
    csum_q <= csum_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = ST_HUNT;
    end else begin
      case (state_q)
        ST_HUNT: if (capture && (q == SYNC_BYTE)) state_d = ST_CMD;
        ST_CMD:  if (capture) state_d = ST_LEN;
        ST_LEN:
          if (capture) begin
            if (len_bad)                 state_d = ST_HUNT;
            else if (cmd_q[CMD_WR_BIT])  state_d = ST_DATA;
            else                         state_d = ST_CSUM;
          end
        ST_DATA: if (capture && last_idx) state_d = ST_CSUM;
        ST_CSUM:
          if (capture) state_d = (csum_match && cmd_q[CMD_WR_BIT]) ? ST_EMIT : ST_HUNT;
        ST_EMIT: if (wr_fire && last_idx) state_d = ST_HUNT;
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    rd_en      = (state_q != ST_EMIT);
    cd_busy_d  = capture || (cd_busy_q && byte_hold);
    tmo_d      = (in_frame && !capture && !timeout) ? tmo_q + TW'(1) : '0;
    cmd_d      = cmd_q;
    csum_d     = csum_q;
    len_d      = len_q;
    idx_d      = idx_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    rd_req_d   = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_len_d   = rd_len_q;
    pkt_ok_d   = 1'b0;
    pkt_err_d  = timeout;
    buf_we     = 1'b0;
    buf_re     = 1'b0;
    buf_raddr  = idx_q[AW-1:0];
    case (state_q)
      ST_CMD:
        if (capture) begin
          cmd_d  = q;
          csum_d = q;
        end
      ST_LEN:
        if (capture) begin
          len_d     = q[4:0];
          csum_d    = csum_q ^ q;
          idx_d     = 5'd0;
          pkt_err_d = len_bad;
        end
      ST_DATA:
        if (capture) begin
          buf_we = 1'b1;
          csum_d = csum_q ^ q;
          idx_d  = idx_nxt;
        end
      ST_CSUM:
        if (capture) begin
          if (!csum_match) begin
            pkt_err_d = 1'b1;
          end else if (cmd_q[CMD_WR_BIT]) begin
            // Fetch buf[0] now so the first write is valid on the next cycle.
            idx_d      = 5'd0;
            buf_re     = 1'b1;
            buf_raddr  = '0;
            wr_valid_d = 1'b1;
            wr_addr_d  = cmd_q[6:0];
          end else begin
            rd_req_d  = 1'b1;
            rd_addr_d = cmd_q[6:0];
            rd_len_d  = len_q;
            pkt_ok_d  = 1'b1;
          end
        end
      ST_EMIT:
        if (wr_fire) begin
          if (last_idx) begin
            wr_valid_d = 1'b0;
            pkt_ok_d   = 1'b1;
          end else begin
            // Prefetch the next word on acceptance; address wraps naturally in 7 bits.
            idx_d     = idx_nxt;
            wr_addr_d = wr_addr_q + 7'd1;
            buf_re    = 1'b1;
            buf_raddr = idx_nxt[AW-1:0];
          end
        end
      default: ;
    endcase
  end

  cmd_payload_buf #(
    .LEN_MAX (LEN_MAX),
    .AW      (AW)
  ) u_buf (
    .clk     (clk),
    .n_rst   (n_rst),
    .we_i    (buf_we),
    .waddr_i (idx_q[AW-1:0]),
    .wdata_i (q),
    .re_i    (buf_re),
    .raddr_i (buf_raddr),
    .rdata_o (wr_data)
  );

  assign cd_busy  = cd_busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign rd_req   = rd_req_q;
  assign rd_addr  = rd_addr_q;
  assign rd_len   = rd_len_q;
  assign pkt_ok   = pkt_ok_q;
  assign pkt_err  = pkt_err_q;

endmodule

// File: tb/tb_cmd_deframer.sv
// Directed bench for cmd_deframer: drives the byte handshake like the FTDI
// controller and checks writes, reads, errors, timeout and reset.
module tb_cmd_deframer;

  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] q;
  logic       byte_hold;
  logic       cd_busy, rd_en, wr_valid, wr_ready;
  logic [6:0] wr_addr, rd_addr;
  logic [7:0] wr_data;
  logic       rd_req, pkt_ok, pkt_err;
  logic [4:0] rd_len;

  cmd_deframer #(.LEN_MAX(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .n_rst(n_rst), .q(q), .byte_hold(byte_hold), .cd_busy(cd_busy),
    .rd_en(rd_en), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .pkt_ok(pkt_ok), .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int         cyc = 0;
  int         wr_n = 0, ok_cnt = 0, err_cnt = 0, rd_cnt = 0, both_cnt = 0;
  int         busy_rises = 0, wv_cycles = 0, rd_en_bad = 0, hold_viol = 0;
  int         ok_cyc = 0, err_cyc = 0, rd_cyc = 0, wv_rise_cyc = 0;
  logic [6:0] log_addr [64];
  logic [7:0] log_data [64];
  logic [6:0] rd_addr_seen;
  logic [4:0] rd_len_seen;
  logic       busy_prev = 1'b0, prev_wv = 1'b0, prev_rdy = 1'b0;
  logic [6:0] prev_addr = 7'd0;
  logic [7:0] prev_data = 8'd0;

  int         cap_cyc;
  int         s_wr, s_ok, s_err, s_rd, s_busy, s_wv, s_rden, s_hold;
  logic [7:0] fr [8];

  localparam logic [32:0] RESET_OUTS = {6'b010000, 27'd0};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_valid && wr_ready) begin
      log_addr[wr_n % 64] = wr_addr;
      log_data[wr_n % 64] = wr_data;
      wr_n++;
    end
    if (wr_valid) wv_cycles++;
    if (wr_valid && !prev_wv) wv_rise_cyc = cyc;
    if (wr_valid && rd_en) rd_en_bad++;
    if (pkt_ok) begin ok_cnt++; ok_cyc = cyc; end
    if (pkt_err) begin err_cnt++; err_cyc = cyc; end
    if (pkt_ok && pkt_err) both_cnt++;
    if (rd_req) begin rd_cnt++; rd_cyc = cyc; rd_addr_seen = rd_addr; rd_len_seen = rd_len; end
    if (cd_busy && !busy_prev) busy_rises++;
    if (prev_wv && !prev_rdy && (!wr_valid || wr_addr != prev_addr || wr_data != prev_data))
      hold_viol++;
    busy_prev = cd_busy;
    prev_wv   = wr_valid;
    prev_rdy  = wr_ready;
    prev_addr = wr_addr;
    prev_data = wr_data;
  end

  function automatic logic [32:0] outs();
    return {cd_busy, rd_en, wr_valid, rd_req, pkt_ok, pkt_err, wr_addr, wr_data, rd_addr, rd_len};
  endfunction

  task automatic snap();
    s_wr = wr_n; s_ok = ok_cnt; s_err = err_cnt; s_rd = rd_cnt;
    s_busy = busy_rises; s_wv = wv_cycles; s_rden = rd_en_bad; s_hold = hold_viol;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(posedge clk); #1;
    q = b; byte_hold = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!cd_busy && n < 20);
    if (!cd_busy) begin
      n_checks++; n_fail++;
      $display("FAIL handshake_ack: cd_busy=%b required 1 for byte %h", cd_busy, b);
    end
    cap_cyc = cyc;
    @(posedge clk); #1;
    byte_hold = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (cd_busy && n < 20);
    if (cd_busy) begin
      n_checks++; n_fail++;
      $display("FAIL handshake_release: cd_busy=%b required 0 after byte %h", cd_busy, b);
    end
  endtask

  task automatic send_frame(input int len);
    for (int i = 0; i < len; i++) send_byte(fr[i]);
  endtask

  task automatic test_reset();
    n_rst = 1'b0; q = 8'h00; byte_hold = 1'b0; wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (outs() !== RESET_OUTS) begin n_fail++; $display("FAIL reset_outputs: got %h required %h", outs(), RESET_OUTS); end
    @(negedge clk); n_rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_write();
    snap();
    wr_ready = 1'b1;
    fr = '{8'hA5, 8'h85, 8'h02, 8'h11, 8'h22, 8'hB4, 8'h00, 8'h00};
    send_frame(6);
    repeat (5) @(posedge clk);
    n_checks++; if (wr_n - s_wr !== 2) begin n_fail++; $display("FAIL wr_count: got %0d required 2", wr_n - s_wr); end
    n_checks++; if ({log_addr[s_wr % 64], log_data[s_wr % 64]} !== {7'h05, 8'h11}) begin n_fail++;
      $display("FAIL wr0: got %h/%h required 05/11", log_addr[s_wr % 64], log_data[s_wr % 64]); end
    n_checks++; if ({log_addr[(s_wr+1) % 64], log_data[(s_wr+1) % 64]} !== {7'h06, 8'h22}) begin n_fail++;
      $display("FAIL wr1: got %h/%h required 06/22", log_addr[(s_wr+1) % 64], log_data[(s_wr+1) % 64]); end
    n_checks++; if (ok_cnt - s_ok !== 1 || err_cnt - s_err !== 0) begin n_fail++;
      $display("FAIL wr_pkt_pulses: ok=%0d err=%0d required 1/0", ok_cnt - s_ok, err_cnt - s_err); end
    n_checks++; if (busy_rises - s_busy !== 6) begin n_fail++; $display("FAIL wr_busy_pulses: got %0d required 6", busy_rises - s_busy); end
    n_checks++; if (wv_rise_cyc - cap_cyc !== 0) begin n_fail++; $display("FAIL wr_first_latency: got %0d required 0", wv_rise_cyc - cap_cyc); end
    n_checks++; if (ok_cyc - cap_cyc !== 2) begin n_fail++; $display("FAIL wr_ok_latency: got %0d required 2", ok_cyc - cap_cyc); end
  endtask

  task automatic test_read();
    snap();
    fr = '{8'hA5, 8'h10, 8'h04, 8'h14, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(4);
    repeat (3) @(posedge clk);
    n_checks++; if (rd_cnt - s_rd !== 1) begin n_fail++; $display("FAIL rd_count: got %0d required 1", rd_cnt - s_rd); end
    n_checks++; if ({rd_addr_seen, rd_len_seen} !== {7'h10, 5'd4}) begin n_fail++;
      $display("FAIL rd_fields: got addr %h len %0d required 10/4", rd_addr_seen, rd_len_seen); end
    n_checks++; if (rd_cyc - cap_cyc !== 0 || ok_cyc - cap_cyc !== 0) begin n_fail++;
      $display("FAIL rd_latency: rd %0d ok %0d required 0/0", rd_cyc - cap_cyc, ok_cyc - cap_cyc); end
    n_checks++; if (ok_cnt - s_ok !== 1 || wv_cycles - s_wv !== 0) begin n_fail++;
      $display("FAIL rd_ok_nowrite: ok %0d wv %0d required 1/0", ok_cnt - s_ok, wv_cycles - s_wv); end
  endtask

  task automatic test_bad_csum();
    snap();
    fr = '{8'hA5, 8'h85, 8'h02, 8'h11, 8'h22, 8'hB5, 8'h00, 8'h00};
    send_frame(6);
    repeat (3) @(posedge clk);
    n_checks++; if (err_cnt - s_err !== 1 || err_cyc - cap_cyc !== 0) begin n_fail++;
      $display("FAIL csum_err: count %0d latency %0d required 1/0", err_cnt - s_err, err_cyc - cap_cyc); end
    n_checks++; if (wv_cycles - s_wv !== 0 || ok_cnt - s_ok !== 0) begin n_fail++;
      $display("FAIL csum_nowrite: wv %0d ok %0d required 0/0", wv_cycles - s_wv, ok_cnt - s_ok); end
    snap();
    fr = '{8'hA5, 8'h8A, 8'h01, 8'h5C, 8'hD7, 8'h00, 8'h00, 8'h00};
    send_frame(5);
    repeat (4) @(posedge clk);
    n_checks++; if (wr_n - s_wr !== 1 || {log_addr[s_wr % 64], log_data[s_wr % 64]} !== {7'h0A, 8'h5C}) begin n_fail++;
      $display("FAIL csum_recover: count %0d got %h/%h required 1 0A/5C", wr_n - s_wr, log_addr[s_wr % 64], log_data[s_wr % 64]); end
  endtask

  task automatic test_wrap_backpressure();
    snap();
    wr_ready = 1'b0;
    fr = '{8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'hEC, 8'h00, 8'h00};
    send_frame(6);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      wr_ready = (i % 3 == 2);
    end
    wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    n_checks++; if (wr_n - s_wr !== 2) begin n_fail++; $display("FAIL bp_count: got %0d required 2", wr_n - s_wr); end
    n_checks++; if ({log_addr[s_wr % 64], log_data[s_wr % 64]} !== {7'h7F, 8'hAA}) begin n_fail++;
      $display("FAIL bp_wr0: got %h/%h required 7F/AA", log_addr[s_wr % 64], log_data[s_wr % 64]); end
    n_checks++; if ({log_addr[(s_wr+1) % 64], log_data[(s_wr+1) % 64]} !== {7'h00, 8'hBB}) begin n_fail++;
      $display("FAIL bp_wr1_wrap: got %h/%h required 00/BB", log_addr[(s_wr+1) % 64], log_data[(s_wr+1) % 64]); end
    n_checks++; if (hold_viol - s_hold !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d violations required 0", hold_viol - s_hold); end
    n_checks++; if (rd_en_bad - s_rden !== 0 || wv_cycles - s_wv < 4) begin n_fail++;
      $display("FAIL bp_rd_en: rd_en high in emit %0d cycles, emit cycles %0d", rd_en_bad - s_rden, wv_cycles - s_wv); end
    n_checks++; if (ok_cnt - s_ok !== 1) begin n_fail++; $display("FAIL bp_ok: got %0d required 1", ok_cnt - s_ok); end
  endtask

  task automatic test_bad_len();
    snap();
    fr = '{8'h00, 8'hFF, 8'hA5, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(5);
    repeat (2) @(posedge clk);
    n_checks++; if (err_cnt - s_err !== 1 || err_cyc - cap_cyc !== 0) begin n_fail++;
      $display("FAIL len0_err: count %0d latency %0d required 1/0", err_cnt - s_err, err_cyc - cap_cyc); end
    snap();
    fr = '{8'hA5, 8'h81, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(3);
    repeat (2) @(posedge clk);
    n_checks++; if (err_cnt - s_err !== 1 || err_cyc - cap_cyc !== 0) begin n_fail++;
      $display("FAIL len17_err: count %0d latency %0d required 1/0", err_cnt - s_err, err_cyc - cap_cyc); end
    n_checks++; if (ok_cnt - s_ok !== 0 || wv_cycles - s_wv !== 0) begin n_fail++;
      $display("FAIL len_nowrite: ok %0d wv %0d required 0/0", ok_cnt - s_ok, wv_cycles - s_wv); end
  endtask

  task automatic test_sync_in_payload();
    snap();
    fr = '{8'hA5, 8'h80, 8'h01, 8'hA5, 8'h24, 8'h00, 8'h00, 8'h00};
    send_frame(5);
    repeat (4) @(posedge clk);
    n_checks++; if (wr_n - s_wr !== 1 || {log_addr[s_wr % 64], log_data[s_wr % 64]} !== {7'h00, 8'hA5}) begin n_fail++;
      $display("FAIL sync_payload: count %0d got %h/%h required 1 00/A5", wr_n - s_wr, log_addr[s_wr % 64], log_data[s_wr % 64]); end
  endtask

  task automatic test_timeout();
    int c0;
    snap();
    send_byte(8'hA5);
    send_byte(8'h85);
    c0 = cap_cyc;
    repeat (TMO + 12) @(posedge clk);
    n_checks++; if (err_cnt - s_err !== 1) begin n_fail++; $display("FAIL tmo_count: got %0d required 1", err_cnt - s_err); end
    n_checks++; if (err_cyc - c0 < TMO - 4 || err_cyc - c0 > TMO + 6) begin n_fail++;
      $display("FAIL tmo_latency: got %0d cycles required about %0d", err_cyc - c0, TMO); end
    snap();
    fr = '{8'hA5, 8'h10, 8'h04, 8'h14, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(4);
    repeat (2) @(posedge clk);
    n_checks++; if (rd_cnt - s_rd !== 1) begin n_fail++; $display("FAIL tmo_recover: got %0d reads required 1", rd_cnt - s_rd); end
  endtask

  task automatic test_reset_midframe();
    snap();
    wr_ready = 1'b0;
    fr = '{8'hA5, 8'h85, 8'h02, 8'h11, 8'h22, 8'hB4, 8'h00, 8'h00};
    send_frame(6);
    repeat (3) @(posedge clk);
    n_checks++; if (wr_valid !== 1'b1 || rd_en !== 1'b0) begin n_fail++;
      $display("FAIL emit_stall: wr_valid %b rd_en %b required 1/0", wr_valid, rd_en); end
    #3 n_rst = 1'b0;
    #1;
    n_checks++; if (outs() !== RESET_OUTS) begin n_fail++; $display("FAIL reset_emit: got %h required %h", outs(), RESET_OUTS); end
    @(negedge clk); n_rst = 1'b1; wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    n_checks++; if (ok_cnt - s_ok !== 0 || err_cnt - s_err !== 0 || wr_n - s_wr !== 0) begin n_fail++;
      $display("FAIL reset_no_pulse: ok %0d err %0d wr %0d required 0/0/0", ok_cnt - s_ok, err_cnt - s_err, wr_n - s_wr); end
    send_byte(8'hA5);
    send_byte(8'h85);
    #2 n_rst = 1'b0;
    #1;
    n_checks++; if (outs() !== RESET_OUTS) begin n_fail++; $display("FAIL reset_frame: got %h required %h", outs(), RESET_OUTS); end
    @(negedge clk); n_rst = 1'b1;
    snap();
    fr = '{8'hA5, 8'h10, 8'h04, 8'h14, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(4);
    repeat (2) @(posedge clk);
    n_checks++; if (rd_cnt - s_rd !== 1 || ok_cnt - s_ok !== 1) begin n_fail++;
      $display("FAIL reset_recover: rd %0d ok %0d required 1/1", rd_cnt - s_rd, ok_cnt - s_ok); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_csum();
    test_wrap_backpressure();
    test_bad_len();
    test_sync_in_payload();
    test_timeout();
    test_reset_midframe();
    n_checks++;
    if (both_cnt !== 0) begin n_fail++; $display("FAIL ok_err_exclusive: got %0d overlapping cycles required 0", both_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
